// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and types used by the register-file write scheduler.
package cpu_pkg;
    localparam int REG_ADDR_W         = 5;
    localparam int XLEN               = 32;
    localparam int STARVE_MAX_DEFAULT = 3;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_WB,
        GRANT_BUF
    } grant_e;
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-destination scoreboard for in-flight MDU ops; x0 is never pending.
module rf_scoreboard
    import cpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic [REG_ADDR_W-1:0] lk_addr_a,
    input  logic [REG_ADDR_W-1:0] lk_addr_b,
    input  logic [REG_ADDR_W-1:0] lk_addr_c,
    output logic                  lk_hit_a,
    output logic                  lk_hit_b,
    output logic                  lk_hit_c
);
    logic [31:0] pending_q;
    logic [31:0] pending_d;

    // Set is applied after clear so a same-edge reissue of a register keeps it pending.
    always_comb begin
        pending_d = pending_q;
        for (int i = 1; i < 32; i++) begin
            if (clr_en && clr_addr == REG_ADDR_W'(i)) pending_d[i] = 1'b0;
            if (set_en && set_addr == REG_ADDR_W'(i)) pending_d[i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) pending_q <= '0;
        else       pending_q <= pending_d;
    end

    assign lk_hit_a = pending_q[lk_addr_a];
    assign lk_hit_b = pending_q[lk_addr_b];
    assign lk_hit_c = pending_q[lk_addr_c];
endmodule

// File: rtl/rf_write_sched.sv
// Arbitrates the single RF write port between the WB stage and a one-entry MDU
// result buffer, with bounded starvation of the buffer and a decode hazard check.
module rf_write_sched
    import cpu_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    output logic                  wb_stall,
    input  logic                  mdu_issue,
    input  logic [REG_ADDR_W-1:0] mdu_issue_rd,
    input  logic                  mdu_res_valid,
    input  logic [REG_ADDR_W-1:0] mdu_res_addr,
    input  logic [XLEN-1:0]       mdu_res_data,
    output logic                  mdu_res_ready,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    output logic                  id_stall,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata
);
    localparam logic [1:0] STARVE_CNT_MAX = 2'(STARVE_MAX);

    logic                  buf_valid_q, buf_valid_d;
    logic [REG_ADDR_W-1:0] buf_addr_q,  buf_addr_d;
    logic [XLEN-1:0]       buf_data_q,  buf_data_d;
    logic [1:0]            starve_cnt_q, starve_cnt_d;
    grant_e                grant;
    logic                  hit_rs1, hit_rs2, hit_rd;

    always_comb begin
        grant = GRANT_NONE;
        if (buf_valid_q && (!wb_valid || starve_cnt_q == STARVE_CNT_MAX)) grant = GRANT_BUF;
        else if (wb_valid)                                                 grant = GRANT_WB;
    end

    // Write port follows the granted source; writes to x0 are suppressed.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = wb_addr;
        rf_wdata = wb_data;
        if (grant == GRANT_BUF) begin
            rf_we    = (buf_addr_q != '0);
            rf_waddr = buf_addr_q;
            rf_wdata = buf_data_q;
        end else if (grant == GRANT_WB) begin
            rf_we = (wb_addr != '0);
        end
    end

    assign wb_stall      = wb_valid && (grant == GRANT_BUF);
    assign mdu_res_ready = !buf_valid_q;

    always_comb begin
        buf_valid_d  = buf_valid_q;
        buf_addr_d   = buf_addr_q;
        buf_data_d   = buf_data_q;
        starve_cnt_d = '0;
        if (grant == GRANT_BUF) begin
            buf_valid_d = 1'b0;
        end else if (buf_valid_q) begin
            // Buffer is occupied and not granted, so WB must have won this cycle.
            starve_cnt_d = (starve_cnt_q == STARVE_CNT_MAX) ? starve_cnt_q : starve_cnt_q + 2'd1;
        end else if (mdu_res_valid) begin
            buf_valid_d = 1'b1;
            buf_addr_d  = mdu_res_addr;
            buf_data_d  = mdu_res_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            buf_valid_q  <= 1'b0;
            buf_addr_q   <= '0;
            buf_data_q   <= '0;
            starve_cnt_q <= '0;
        end else begin
            buf_valid_q  <= buf_valid_d;
            buf_addr_q   <= buf_addr_d;
            buf_data_q   <= buf_data_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    rf_scoreboard u_scoreboard (
        .clk       (clk),
        .rstn      (rstn),
        .set_en    (mdu_issue),
        .set_addr  (mdu_issue_rd),
        .clr_en    (grant == GRANT_BUF),
        .clr_addr  (buf_addr_q),
        .lk_addr_a (id_rs1),
        .lk_addr_b (id_rs2),
        .lk_addr_c (id_rd),
        .lk_hit_a  (hit_rs1),
        .lk_hit_b  (hit_rs2),
        .lk_hit_c  (hit_rd)
    );

    assign id_stall = hit_rs1 | hit_rs2 | hit_rd;
endmodule

// File: tb/tb_rf_write_sched.sv
// Scoreboard bench for rf_write_sched: expected RF writes are queued by the
// stimulus/model process and checked by an independent write-port monitor.
module tb_rf_write_sched;
    localparam int SMAX = 3;

    logic        clk;
    logic        rstn;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        mdu_issue;
    logic [4:0]  mdu_issue_rd;
    logic        mdu_res_valid;
    logic [4:0]  mdu_res_addr;
    logic [31:0] mdu_res_data;
    logic        mdu_res_ready;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    rf_write_sched #(.STARVE_MAX(SMAX)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .wb_stall      (wb_stall),
        .mdu_issue     (mdu_issue),
        .mdu_issue_rd  (mdu_issue_rd),
        .mdu_res_valid (mdu_res_valid),
        .mdu_res_addr  (mdu_res_addr),
        .mdu_res_data  (mdu_res_data),
        .mdu_res_ready (mdu_res_ready),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .id_stall      (id_stall),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [36:0] exp_q[$];

    // Reference state: what the register file writer is holding and who is waiting.
    bit          m_bv;
    logic [4:0]  m_ba;
    logic [31:0] m_bd;
    int          m_lost;
    bit   [31:0] m_pend;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every RF write the DUT performs must be the next expected one.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {27'd0, rf_waddr, rf_wdata}, 64'h0);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                $display("write x%0d = %08h (expected x%0d = %08h)", rf_waddr, rf_wdata, e[36:32], e[31:0]);
                chk("rf_write", {27'd0, rf_waddr, rf_wdata}, {27'd0, e});
            end
        end
    end

    task automatic cyc(input bit r_n, input bit wv, input logic [4:0] wa, input logic [31:0] wd,
                       input bit iss, input logic [4:0] ird,
                       input bit rv, input logic [4:0] ra, input logic [31:0] rdat,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] sd);
        bit buf_win;
        bit acc;
        @(posedge clk);
        #1;
        rstn = r_n; wb_valid = wv; wb_addr = wa; wb_data = wd;
        mdu_issue = iss; mdu_issue_rd = ird;
        mdu_res_valid = rv; mdu_res_addr = ra; mdu_res_data = rdat;
        id_rs1 = s1; id_rs2 = s2; id_rd = sd;
        if (!r_n) begin
            m_bv = 0; m_lost = 0; m_pend = '0;
        end
        // A buffered result goes first when WB is idle or it has already lost SMAX times.
        buf_win = m_bv && (!wv || m_lost == SMAX);
        if (buf_win) begin
            if (m_ba != 0) exp_q.push_back({m_ba, m_bd});
        end else if (wv && wa != 0) begin
            exp_q.push_back({wa, wd});
        end
        #3;
        chk("wb_stall", {63'd0, wb_stall}, {63'd0, wv && buf_win});
        chk("mdu_res_ready", {63'd0, mdu_res_ready}, {63'd0, !m_bv});
        chk("id_stall", {63'd0, id_stall}, {63'd0, m_pend[s1] | m_pend[s2] | m_pend[sd]});
        if (r_n) begin
            acc = rv && !m_bv;
            if (buf_win) begin
                m_bv = 0; m_pend[m_ba] = 1'b0; m_lost = 0;
            end else if (m_bv && wv) begin
                m_lost = (m_lost == SMAX) ? m_lost : m_lost + 1;
            end
            if (acc) begin
                m_bv = 1; m_ba = ra; m_bd = rdat; m_lost = 0;
            end
            if (iss && ird != 0) m_pend[ird] = 1'b1;
            m_pend[0] = 1'b0;
        end
    endtask

    task automatic idle(input logic [4:0] s1, input logic [4:0] s2);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, s1, s2, 0);
    endtask

    initial begin
        rstn = 0; wb_valid = 0; wb_addr = 0; wb_data = 0;
        mdu_issue = 0; mdu_issue_rd = 0; mdu_res_valid = 0; mdu_res_addr = 0; mdu_res_data = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        m_bv = 0; m_ba = 0; m_bd = 0; m_lost = 0; m_pend = '0;

        // Reset: WB still reaches the port, nothing else active.
        cyc(0, 0, 0, 0, 0, 0, 1, 5'd6, 32'h11111111, 5'd6, 0, 0);
        cyc(0, 1, 5'd2, 32'h0000_0222, 1, 5'd2, 0, 0, 0, 5'd2, 0, 0);

        // Single MDU result with WB idle, written the next cycle.
        cyc(1, 0, 0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        idle(0, 0);
        idle(0, 0);

        // Buffered x7 starved by continuous WB to x3, then forced through.
        cyc(1, 0, 0, 0, 0, 0, 1, 5'd7, 32'h7777_0007, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(1, 1, 5'd3, 32'h3300_0000 + i, 0, 0, 0, 0, 0, 0, 0, 0);

        // Hazard on x9 until its result is written.
        cyc(1, 0, 0, 0, 1, 5'd9, 0, 0, 0, 5'd9, 0, 0);
        idle(5'd9, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 5'd9, 32'h9999_9999, 5'd9, 0, 0);
        idle(5'd9, 0);
        idle(5'd9, 0);

        // Same-edge clear and reissue of x4 keeps it pending.
        cyc(1, 0, 0, 0, 1, 5'd4, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 5'd4, 32'h4444_4444, 0, 5'd4, 0);
        cyc(1, 0, 0, 0, 1, 5'd4, 0, 0, 0, 0, 5'd4, 0);
        idle(0, 5'd4);
        cyc(1, 0, 0, 0, 0, 0, 1, 5'd4, 32'h4444_0002, 0, 5'd4, 0);
        idle(0, 5'd4);
        idle(0, 5'd4);

        // Results and writebacks to x0 never write.
        cyc(1, 1, 5'd0, 32'hAAAA_AAAA, 0, 0, 1, 5'd0, 32'hBBBB_BBBB, 0, 0, 0);
        cyc(1, 1, 5'd0, 32'hCCCC_CCCC, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 0);

        // Reset while x12 is buffered and pending: both are discarded.
        cyc(1, 0, 0, 0, 1, 5'd12, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 5'd1, 32'h0101_0101, 0, 0, 1, 5'd12, 32'h1212_1212, 5'd12, 0, 0);
        cyc(1, 1, 5'd1, 32'h0101_0102, 0, 0, 0, 0, 0, 5'd12, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd12, 0, 0);
        idle(5'd12, 0);
        idle(5'd12, 0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            bit          r_n, wv, iss, rv;
            logic [4:0]  wa, ird, ra, s1, s2, sd;
            logic [31:0] wd, rdat;
            r_n  = ($urandom_range(0, 199) != 0);
            wv   = ($urandom_range(0, 9) < 7);
            wa   = 5'($urandom_range(0, 15));
            while (m_pend[wa]) wa = 5'($urandom_range(0, 15));
            wd   = $urandom;
            iss  = ($urandom_range(0, 3) == 0);
            ird  = 5'($urandom_range(0, 15));
            rv   = ($urandom_range(0, 2) == 0);
            ra   = 5'($urandom_range(0, 15));
            rdat = $urandom;
            s1   = 5'($urandom_range(0, 15));
            s2   = 5'($urandom_range(0, 15));
            sd   = 5'($urandom_range(0, 15));
            cyc(r_n, wv, wa, wd, iss, ird, rv, ra, rdat, s1, s2, sd);
        end

        for (int i = 0; i < SMAX + 3; i++) idle(0, 0);
        @(posedge clk);
        #1;
        chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rf_write_sched.md
RF_WRITE_SCHED -- requirements
Module: rf_write_sched

Interface
REQ-001 Parameter STARVE_MAX, default 3: consecutive cycles a buffered MDU result may lose to writeback before it is forced through.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 wb_valid  input  1  pipeline WB stage requests a register write.
REQ-005 wb_addr  input  5  WB destination register.
REQ-006 wb_data  input  32  WB write data.
REQ-007 wb_stall  output  1  WB write not performed this cycle; pipeline holds WB stage.
REQ-008 mdu_issue  input  1  decode issues a multi-cycle MDU op this cycle.
REQ-009 mdu_issue_rd  input  5  destination of the issued MDU op.
REQ-010 mdu_res_valid  input  1  MDU result available.
REQ-011 mdu_res_addr  input  5  MDU result destination.
REQ-012 mdu_res_data  input  32  MDU result data.
REQ-013 mdu_res_ready  output  1  block accepts the MDU result this cycle.
REQ-014 id_rs1, id_rs2, id_rd  input  5 each  register addresses of the instruction in decode.
REQ-015 id_stall  output  1  decode instruction has a hazard on a pending MDU destination.
REQ-016 rf_we, rf_waddr, rf_wdata  output  1/5/32  single write port of the register file.

Function
REQ-017 One-entry result buffer (buf_valid, buf_addr, buf_data); mdu_res_ready SHALL equal ~buf_valid; result captured on edge when mdu_res_valid & mdu_res_ready.
REQ-018 Grant: buffer SHALL win when buf_valid and (~wb_valid or starve_cnt == STARVE_MAX); otherwise WB wins when wb_valid.
REQ-019 rf_we/rf_waddr/rf_wdata SHALL be combinational from the granted source; rf_we SHALL be 0 when granted address is 0 or no source requests.
REQ-020 wb_stall SHALL be 1 exactly when wb_valid and the buffer is granted.
REQ-021 buf_valid SHALL clear on the edge the buffer is granted; buffer SHALL NOT accept a new result in that same cycle (ready already low).
REQ-022 starve_cnt (2 bits) SHALL increment, saturating at STARVE_MAX, when buf_valid and WB wins; SHALL clear when buffer is granted or buf_valid is 0.
REQ-023 Result with buf_addr 0 SHALL be drained with rf_we = 0 and no scoreboard effect.
REQ-024 Scoreboard pending[31:1]: mdu_issue with mdu_issue_rd != 0 SHALL set pending[rd]; buffer grant SHALL clear pending[buf_addr]; same-edge set and clear of one register: set wins.
REQ-025 id_stall SHALL be combinational: pending[id_rs1] | pending[id_rs2] | pending[id_rd], register 0 never pending.
REQ-026 Latency: MDU result reaches RF write port no earlier than one cycle after acceptance, no later than STARVE_MAX+1 cycles after acceptance.
REQ-027 wb_addr equal to a pending register is a protocol violation prevented by id_stall; block behaviour then is unspecified.

Reset
REQ-028 While rstn low: buf_valid 0, starve_cnt 0, pending all 0; hence rf_we 0 unless wb_valid, mdu_res_ready 1, id_stall 0, wb_stall 0.
REQ-029 Reset mid-operation SHALL discard the buffered result and all pending bits; no RF write of discarded data after release.

Structure
REQ-030 Shared package cpu_pkg SHALL hold REG_ADDR_W = 5, XLEN = 32, STARVE_MAX default.
REQ-031 Scoreboard SHALL be sub-module rf_scoreboard (set port, clear port, three lookup ports); arbitration and buffer in top.

Verification
REQ-032 Reset, MDU result x5=0xDEADBEEF with wb idle -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, mdu_res_ready low one cycle.
REQ-033 Buffer holds x7, wb_valid continuous to x3 -> WB wins 3 cycles, 4th cycle rf_waddr=7, wb_stall=1, then WB resumes.
REQ-034 mdu_issue rd=9, decode rs1=9 -> id_stall=1 until the edge x9 is written, 0 on following cycle.
REQ-035 Same cycle: buffer grant clears x4 and mdu_issue rd=4 -> pending[4] stays 1, id_stall for rs2=4 remains 1.
REQ-036 MDU result to x0 and wb to x0 -> rf_we=0 throughout, buffer drains, no stall.
REQ-037 rstn low with buf_valid=1 and pending[12]=1 -> immediately buf_valid=0, id_stall=0, no write to x12 after release.
